// File: rtl/div_iter32_pkg.sv
// div_iter32_pkg: shared types and constants for the iterative signed divider.
// Latency: n/a (declarations only).  Backpressure: n/a.
// Contents: FSM state encoding, default widths, INT_MIN, exception codes.
package div_iter32_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  // Most negative two's-complement value; its magnitude is only representable unsigned.
  localparam logic [DIV_WIDTH-1:0] INT_MIN = 32'h8000_0000;

  // Exception flag values driven on data_exception.
  localparam logic EXC_NONE  = 1'b0;
  localparam logic EXC_FAULT = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div_iter32_step.sv
// div_iter32_step: one combinational restoring-division step (shift, trial subtract, restore).
// Latency: combinational.  Backpressure: none; the caller decides when to register the result.
// Ports: rem/quo = current partial remainder and quotient shift register, dvs = |divisor|;
//        rem_nxt/quo_nxt = values after this step.
module div_iter32_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  // Bring the next dividend bit (MSB of the quotient register) into the remainder.
  assign rem_sh = {rem[WIDTH-1:0], quo[WIDTH-1]};
  // Remainder stays below |divisor| <= 2^(WIDTH-1), so a WIDTH+1 bit trial never wraps
  // and its top bit is a reliable sign.
  assign trial  = rem_sh - {1'b0, dvs};

  always_comb begin
    rem_nxt = rem_sh;
    quo_nxt = {quo[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_nxt = trial;
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_iter32.sv
// div_iter32: multi-cycle signed integer divider, quotient truncated toward zero.
// Latency: fixed, data_resultRDY pulses 33 cycles after the ctrl_div edge for any operands.
// Backpressure: none; a new ctrl_div pulse abandons any operation in flight and restarts.
// Ports: clock, reset (sync, active-high), ctrl_div (start pulse, operands sampled same edge),
//        data_operandA/B (dividend/divisor), data_result, data_exception, data_resultRDY.
module div_iter32
  import div_iter32_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] div_mag;
  logic             q_neg;
  logic             exc;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             start_exc;
  logic [WIDTH:0]   rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  // Magnitudes are treated as unsigned, so negating MIN_VAL yields 2^(WIDTH-1) correctly.
  assign a_mag     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign b_mag     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
  assign start_exc = (data_operandB == '0) ||
                     ((data_operandA == MIN_VAL) && (data_operandB == '1));

  div_iter32_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem),
    .quo     (quo),
    .dvs     (div_mag),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_IDLE;
      count          <= '0;
      rem            <= '0;
      quo            <= '0;
      div_mag        <= '0;
      q_neg          <= 1'b0;
      exc            <= EXC_NONE;
      data_result    <= '0;
      data_exception <= EXC_NONE;
      data_resultRDY <= 1'b0;
    end else if (ctrl_div) begin
      // Restart from any state; an operation in flight is dropped without a RDY pulse.
      state          <= S_RUN;
      count          <= '0;
      rem            <= '0;
      quo            <= a_mag;
      div_mag        <= b_mag;
      q_neg          <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      exc            <= start_exc ? EXC_FAULT : EXC_NONE;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      unique case (state)
        S_IDLE: state <= S_IDLE;
        S_RUN: begin
          rem   <= rem_nxt;
          quo   <= quo_nxt;
          count <= count + 1'b1;
          if (count == LAST_CNT) state <= S_FIX;
        end
        S_FIX: begin
          // Negating a zero quotient gives zero, so no -0 special case is needed.
          data_result    <= exc ? '0 : (q_neg ? -quo : quo);
          data_exception <= exc;
          data_resultRDY <= 1'b1;
          state          <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter32.sv
// tb_div_iter32: directed test of the iterative divider against a behavioural model.
// Latency: n/a.  Backpressure: n/a.
// The model predicts RDY timing, quotient and exception from integer arithmetic.
module tb_div_iter32;
  import div_iter32_pkg::*;

  logic        clock;
  logic        reset;
  logic        ctrl_div;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] result;
  logic        exception;
  logic        rdy;

  int tests = 0;
  int fails = 0;

  div_iter32 dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_div       (ctrl_div),
    .data_operandA  (op_a),
    .data_operandB  (op_b),
    .data_result    (result),
    .data_exception (exception),
    .data_resultRDY (rdy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the outputs must be after each rising edge.
  int          edge_n    = 0;
  bit          live      = 1'b0;
  bit          m_pending = 1'b0;
  int          m_due     = 0;
  logic [31:0] m_nres    = '0;
  logic        m_nexc    = 1'b0;
  logic [31:0] m_res     = '0;
  logic        m_exc     = 1'b0;
  logic        m_rdy     = 1'b0;

  always @(posedge clock) begin
    edge_n = edge_n + 1;
    live   = 1'b1;
    m_rdy  = 1'b0;
    if (reset) begin
      m_pending = 1'b0;
      m_res     = '0;
      m_exc     = 1'b0;
    end else if (ctrl_div) begin
      m_pending = 1'b1;
      m_due     = edge_n + 33;
      if (op_b == 32'd0 || (op_a == INT_MIN && op_b == 32'hFFFF_FFFF)) begin
        m_nres = '0;
        m_nexc = 1'b1;
      end else begin
        m_nres = $signed(op_a) / $signed(op_b);
        m_nexc = 1'b0;
      end
    end else if (m_pending && edge_n == m_due) begin
      m_pending = 1'b0;
      m_rdy     = 1'b1;
      m_res     = m_nres;
      m_exc     = m_nexc;
    end
  end

  // Compare process: outputs checked against the model every cycle, away from the edge.
  always @(negedge clock) begin
    if (live) begin
      chk("model_rdy", {31'd0, rdy}, {31'd0, m_rdy});
      chk("model_result", result, m_res);
      chk("model_exception", {31'd0, exception}, {31'd0, m_exc});
    end
  end

  // Called at a falling edge; pulses ctrl_div and measures edges until RDY.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_exc, input string name);
    int lat;
    op_a     = a;
    op_b     = b;
    ctrl_div = 1'b1;
    @(posedge clock);
    @(negedge clock);
    ctrl_div = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      if (rdy) break;
    end
    if (!rdy) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: no RDY within %0d cycles", name, lat);
    end else begin
      chk({name, "_latency"}, lat, 32'd33);
      chk({name, "_result"}, result, exp_res);
      chk({name, "_exception"}, {31'd0, exception}, {31'd0, exp_exc});
    end
  endtask

  task automatic expect_quiet(input string name);
    int n_rdy = 0;
    repeat (40) begin
      @(negedge clock);
      if (rdy) n_rdy++;
    end
    chk(name, n_rdy, 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    ctrl_div = 1'b0;
    op_a     = '0;
    op_b     = '0;
    repeat (3) @(negedge clock);
    chk("reset_result", result, 32'd0);
    chk("reset_exception", {31'd0, exception}, 32'd0);
    chk("reset_rdy", {31'd0, rdy}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Back-to-back calls also exercise a restart landing on the DONE cycle.
    run_op(32'd7, 32'd2, 32'd3, 1'b0, "pos_pos");
    run_op(-32'sd7, 32'd2, -32'sd3, 1'b0, "neg_pos");
    run_op(32'd7, -32'sd2, -32'sd3, 1'b0, "pos_neg");
    run_op(-32'sd7, -32'sd2, 32'd3, 1'b0, "neg_neg");
    run_op(32'd0, -32'sd5, 32'd0, 1'b0, "zero_dividend");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, "overflow");
    run_op(32'd12345, 32'd0, 32'd0, 1'b1, "div_by_zero");
    run_op(32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, "int_min_by_1");
    run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd1, 1'b0, "max_by_max");
    run_op(-32'sd100, 32'd7, -32'sd14, 1'b0, "truncate_neg");
    run_op(32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, "m1_by_int_min");
    run_op(32'h8000_0000, 32'h8000_0000, 32'd1, 1'b0, "int_min_by_self");

    // Re-pulse at cycle 10 of an operation: only the second one reports.
    @(negedge clock);
    op_a     = 32'd100;
    op_b     = 32'd7;
    ctrl_div = 1'b1;
    @(posedge clock);
    @(negedge clock);
    ctrl_div = 1'b0;
    repeat (9) @(negedge clock);
    run_op(32'd9, 32'd3, 32'd3, 1'b0, "repulse");
    expect_quiet("repulse_single_rdy");

    // Reset at cycle 15 of an operation clears held outputs and suppresses RDY.
    op_a     = 32'd7;
    op_b     = 32'd2;
    ctrl_div = 1'b1;
    @(posedge clock);
    @(negedge clock);
    ctrl_div = 1'b0;
    repeat (14) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midreset_result", result, 32'd0);
    chk("midreset_exception", {31'd0, exception}, 32'd0);
    chk("midreset_rdy", {31'd0, rdy}, 32'd0);
    expect_quiet("midreset_no_rdy");

    // Reset and start on the same edge: reset wins.
    op_a     = 32'd5;
    op_b     = 32'd1;
    reset    = 1'b1;
    ctrl_div = 1'b1;
    @(negedge clock);
    reset    = 1'b0;
    ctrl_div = 1'b0;
    expect_quiet("reset_beats_start");

    run_op(-32'sd7, 32'd2, -32'sd3, 1'b0, "after_reset");
    repeat (3) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
